// File: rtl/check_collision.sv
// rtl/check_collision.sv - tetromino collision checker reading the four board-RAM cells of a candidate placement
//
// Purpose:
//   For a candidate tetromino (anchor x/y, block type, rotation) this block visits the
//   four board cells that the piece would occupy and reads each one from the board RAM.
//   It reports a collision when any cell is occupied (ram_q != 0) or lies off the board.
//   It uses the same offset table and y*BOARD_W+x addressing as the piece-store path.
//
// Optional feature (compile-time macro):
//   CHECK_EARLY_EXIT_EN - when defined, the first hit ends the check at once and the
//                         remaining cells are not read. When undefined, all four cells
//                         are always read and the latency is fixed at 4*(2+RAM_LAT)+1.
//
// Ports:
//   clk       in   1  system clock, all logic on posedge
//   reset     in   1  synchronous, active-high reset
//   start     in   1  request a check; accepted only while busy=0
//   x_anc     in   5  candidate anchor column
//   y_anc     in   6  candidate anchor row
//   block     in   3  tetromino type
//   rotation  in   2  rotation, quarter turns clockwise
//   ram_addr  out  8  board-RAM read address (0 for off-board cells)
//   ram_rden  out  1  read strobe, high while ram_addr is valid
//   ram_q     in   6  board-RAM read data; nonzero means occupied
//   busy      out  1  check in progress
//   done      out  1  one-cycle pulse when collide is valid
//   collide   out  1  result; held from done until the next accepted start

module check_collision #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 24,
  parameter int RAM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] x_anc,
  input  logic [5:0] y_anc,
  input  logic [2:0] block,
  input  logic [1:0] rotation,
  output logic [7:0] ram_addr,
  output logic       ram_rden,
  input  logic [5:0] ram_q,
  output logic       busy,
  output logic       done,
  output logic       collide
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  // The address is truncated to 8 bits anyway, so the multiply can run modulo 256.
  localparam logic [7:0] BOARD_W8  = 8'(BOARD_W);
  localparam logic [1:0] WAIT_INIT = 2'(RAM_LAT - 1);

  // Offset table: {y_offsets, x_offsets}; cell i uses bits [2i+1:2i].
  // Base shapes sit in a 4x4 box with cells listed in row-major order; rotation r
  // turns the box r quarter turns clockwise: (x,y) -> (3-y, x). Inside a 2-bit
  // box 3-v is simply ~v.
  function automatic logic [15:0] offsets_lut(input logic [2:0] blk, input logic [1:0] rot);
    logic [7:0] bx;
    logic [7:0] by;
    logic [7:0] rx;
    logic [7:0] ry;
    logic [1:0] cx;
    logic [1:0] cy;
    rx = '0;
    ry = '0;
    case (blk)
      3'd0:    begin bx = 8'b11_10_01_00; by = 8'b01_01_01_01; end // I
      3'd1:    begin bx = 8'b10_01_10_01; by = 8'b01_01_00_00; end // O
      3'd2:    begin bx = 8'b10_01_00_01; by = 8'b01_01_01_00; end // T
      3'd3:    begin bx = 8'b01_00_10_01; by = 8'b01_01_00_00; end // S
      3'd4:    begin bx = 8'b10_01_01_00; by = 8'b01_01_00_00; end // Z
      3'd5:    begin bx = 8'b10_01_00_00; by = 8'b01_01_01_00; end // J
      3'd6:    begin bx = 8'b10_01_00_10; by = 8'b01_01_01_00; end // L
      default: begin bx = 8'b10_01_10_01; by = 8'b01_01_00_00; end // unused code aliases O
    endcase
    for (int i = 0; i < 4; i++) begin
      cx = bx[2*i +: 2];
      cy = by[2*i +: 2];
      case (rot)
        2'd0:    begin rx[2*i +: 2] = cx;  ry[2*i +: 2] = cy;  end
        2'd1:    begin rx[2*i +: 2] = ~cy; ry[2*i +: 2] = cx;  end
        2'd2:    begin rx[2*i +: 2] = ~cx; ry[2*i +: 2] = ~cy; end
        default: begin rx[2*i +: 2] = cy;  ry[2*i +: 2] = ~cx; end
      endcase
    end
    return {ry, rx};
  endfunction

  state_t     state_q, state_d;
  logic [1:0] cell_q, cell_d;
  logic [1:0] wait_q, wait_d;
  logic       oob_q, oob_d;
  logic       collide_q, collide_d;
  logic [4:0] x_q, x_d;
  logic [5:0] y_q, y_d;
  logic [2:0] blk_q, blk_d;
  logic [1:0] rot_q, rot_d;

  logic [15:0] offs;
  logic [1:0]  xoff;
  logic [1:0]  yoff;
  logic [5:0]  cell_x;
  logic [6:0]  cell_y;
  logic        cell_oob;
  logic [7:0]  cell_addr;
  logic        hit;

  // Geometry of the current cell from the latched candidate.
  always_comb begin
    offs      = offsets_lut(blk_q, rot_q);
    xoff      = offs[2*cell_q +: 2];
    yoff      = offs[8 + 2*cell_q +: 2];
    cell_x    = {1'b0, x_q} + {4'b0000, xoff};
    cell_y    = {1'b0, y_q} + {5'b00000, yoff};
    cell_oob  = (32'(cell_x) >= 32'(BOARD_W)) || (32'(cell_y) >= 32'(BOARD_H));
    cell_addr = cell_oob ? 8'd0 : ({1'b0, cell_y} * BOARD_W8 + {2'b00, cell_x});
  end

  always_comb begin
    state_d   = state_q;
    cell_d    = cell_q;
    wait_d    = wait_q;
    oob_d     = oob_q;
    collide_d = collide_q;
    x_d       = x_q;
    y_d       = y_q;
    blk_d     = blk_q;
    rot_d     = rot_q;
    ram_addr  = 8'd0;
    ram_rden  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    hit       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d       = x_anc;
          y_d       = y_anc;
          blk_d     = block;
          rot_d     = rotation;
          cell_d    = 2'd0;
          collide_d = 1'b0;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        busy     = 1'b1;
        ram_rden = 1'b1;
        ram_addr = cell_addr;
        oob_d    = cell_oob;
        wait_d   = WAIT_INIT;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_q == 2'd0) begin
          state_d = S_SAMPLE;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      S_SAMPLE: begin
        busy      = 1'b1;
        // An off-board cell was still read at address 0; its data is ignored.
        hit       = oob_q || (ram_q != 6'd0);
        collide_d = collide_q | hit;
        if (cell_q == 2'd3) begin
          state_d = S_FIN;
        end else begin
          cell_d  = cell_q + 2'd1;
          state_d = S_ADDR;
        end
`ifdef CHECK_EARLY_EXIT_EN
        if (hit) begin
          state_d = S_FIN;
        end
`endif
      end
      S_FIN: begin
        // busy is already low here, but start is only honoured from IDLE.
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cell_q    <= 2'd0;
      wait_q    <= 2'd0;
      oob_q     <= 1'b0;
      collide_q <= 1'b0;
      x_q       <= 5'd0;
      y_q       <= 6'd0;
      blk_q     <= 3'd0;
      rot_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      cell_q    <= cell_d;
      wait_q    <= wait_d;
      oob_q     <= oob_d;
      collide_q <= collide_d;
      x_q       <= x_d;
      y_q       <= y_d;
      blk_q     <= blk_d;
      rot_q     <= rot_d;
    end
  end

  assign collide = collide_q;

endmodule
